// File: rtl/flop_arb_pkg.sv
// Shared types and default constants for the flop_arbiter codebase slice.
package flop_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/flop_reg.sv
// Shared WIDTH-bit register with load enable and synchronous active-low reset to 0.
module flop_reg
    import flop_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/flop_arbiter.sv
// Round-robin arbiter with lock for a shared register (flop_reg).
// Optional per-requester saturating grant counters when FLOP_ARB_CNT_EN is defined.
//
// state  | meaning
// IDLE   | round-robin search from ptr among all requesters
// LOCKED | only requester owner is eligible; ptr frozen
module flop_arbiter
    import flop_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef FLOP_ARB_CNT_EN
    input  logic [PW-1:0]         cnt_sel,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt_out,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      qout,
    output logic [PW-1:0]         owner,
    output logic                  locked
);

    arb_state_e    state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt, owner_nxt, gidx;
    logic          load;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin : arb_comb
        int  idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        gnt       = '0;
        gidx      = '0;
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (state == IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ)
                    idx = idx - NREQ;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    gidx  = PW'(idx);
                end
            end
            if (found) begin
                gnt[gidx] = 1'b1;
                owner_nxt = gidx;
                ptr_nxt   = wrap_inc(gidx);
                if (lock[gidx])
                    state_nxt = LOCKED;
            end
        end else begin
            gidx       = owner;
            gnt[owner] = req[owner];
            // Lock released: leave whether or not a final write happens this cycle.
            if (!lock[owner]) begin
                state_nxt = IDLE;
                ptr_nxt   = wrap_inc(owner);
            end
        end
        if (!reset)
            gnt = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    assign load   = |gnt;
    assign locked = (state == LOCKED);

    flop_reg #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (wdata[gidx*WIDTH +: WIDTH]),
        .q     (qout)
    );

`ifdef FLOP_ARB_CNT_EN
    logic [CNT_W-1:0] cnt [NREQ];

    always_ff @(posedge clk) begin
        if (!reset || cnt_clr) begin
            for (int i = 0; i < NREQ; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (gnt[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end

    assign cnt_out = (int'(cnt_sel) < NREQ) ? cnt[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_flop_arbiter.sv
// Scoreboard bench for flop_arbiter: stimulus pushes expected grant/data, a monitor pops and checks.
module tb_flop_arbiter;
    import flop_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] qout;
    logic [1:0]       owner;
    logic             locked;
`ifdef FLOP_ARB_CNT_EN
    logic [1:0]       cnt_sel;
    logic             cnt_clr;
    logic [7:0]       cnt_out;
`endif

    flop_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
`ifdef FLOP_ARB_CNT_EN
        .cnt_sel(cnt_sel),
        .cnt_clr(cnt_clr),
        .cnt_out(cnt_out),
`endif
        .gnt    (gnt),
        .qout   (qout),
        .owner  (owner),
        .locked (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  g;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: qout one cycle after each grant must equal the granted data.
    logic             pend = 1'b0;
    logic [WIDTH-1:0] pend_d;
    always @(negedge clk) begin
        if (pend) begin
            chk("qout_after_gnt", 32'(qout), 32'(pend_d));
            pend = 1'b0;
        end
        if (gnt !== '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.g));
                pend   = 1'b1;
                pend_d = e.d;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
`ifdef FLOP_ARB_CNT_EN
        cnt_sel = '0;
        cnt_clr = 1'b0;
`endif
        // Reset with all requesting: gnt forced low.
        #1;
        req = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            chk("gnt_in_reset", 32'(gnt), 32'(0));
        end
        cycle();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk("rst_qout", 32'(qout), 32'h00);
        chk("rst_owner", 32'(owner), 32'(0));
        chk("rst_locked", 32'(locked), 32'(0));
        cycle();

        // Round robin over all four.
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        push(4'b0001, 8'h10);
        push(4'b0010, 8'h11);
        push(4'b0100, 8'h12);
        push(4'b1000, 8'h13);
        push(4'b0001, 8'h10);
        req = 4'b1111;
        repeat (5) cycle();
        req = '0;
        cycle();

        // ptr=1 -> grant 2 alone, leaving ptr=3; then wrap and skip.
        wdata = {8'h00, 8'h22, 8'h00, 8'h00};
        push(4'b0100, 8'h22);
        req = 4'b0100;
        cycle();
        wdata = {8'h00, 8'h32, 8'h00, 8'h30};
        push(4'b0001, 8'h30);
        push(4'b0100, 8'h32);
        req = 4'b0101;
        cycle();
        cycle();
        req = '0;
        cycle();

        // Grant 1 alone to move ptr to 2 ahead of the lock test.
        wdata = {8'h00, 8'h00, 8'h41, 8'h00};
        push(4'b0010, 8'h41);
        req = 4'b0010;
        cycle();

        // Lock by requester 2 with requester 0 competing.
        push(4'b0100, 8'hA5);
        push(4'b0100, 8'hA6);
        push(4'b0100, 8'hA7);
        req   = 4'b0101;
        lock  = 4'b0100;
        wdata = {8'h00, 8'hA5, 8'h00, 8'h01};
        @(negedge clk);
        chk("lock_c1_locked", 32'(locked), 32'(0));
        cycle();
        wdata[2*WIDTH +: WIDTH] = 8'hA6;
        @(negedge clk);
        chk("lock_c2_locked", 32'(locked), 32'(1));
        chk("lock_c2_gnt0", 32'(gnt[0]), 32'(0));
        cycle();
        lock = '0;
        wdata[2*WIDTH +: WIDTH] = 8'hA7;
        @(negedge clk);
        chk("lock_c3_locked", 32'(locked), 32'(1));
        chk("lock_c3_gnt0", 32'(gnt[0]), 32'(0));
        cycle();
        req   = 4'b1001;
        wdata = {8'h53, 8'h00, 8'h00, 8'h50};
        push(4'b1000, 8'h53);
        @(negedge clk);
        chk("unlock_locked", 32'(locked), 32'(0));
        chk("unlock_owner", 32'(owner), 32'(2));
        cycle();
        req = '0;
        cycle();

        // Reset while LOCKED abandons the lock with no write.
        push(4'b0010, 8'h61);
        req   = 4'b0010;
        lock  = 4'b0010;
        wdata = {8'h00, 8'h00, 8'h61, 8'h00};
        cycle();
        reset = 1'b0;
        wdata[1*WIDTH +: WIDTH] = 8'h62;
        @(negedge clk);
        chk("rstlock_locked_before", 32'(locked), 32'(1));
        chk("rstlock_gnt", 32'(gnt), 32'(0));
        cycle();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        @(negedge clk);
        chk("rstlock_qout", 32'(qout), 32'h00);
        chk("rstlock_locked", 32'(locked), 32'(0));
        chk("rstlock_owner", 32'(owner), 32'(0));
        cycle();

        // Lock released with req low: exit without a write.
        push(4'b0100, 8'h71);
        req   = 4'b0100;
        lock  = 4'b0100;
        wdata = {8'h00, 8'h71, 8'h00, 8'h00};
        cycle();
        req  = '0;
        lock = '0;
        wdata[2*WIDTH +: WIDTH] = 8'h72;
        @(negedge clk);
        chk("idle_exit_locked1", 32'(locked), 32'(1));
        chk("idle_exit_gnt", 32'(gnt), 32'(0));
        cycle();
        @(negedge clk);
        chk("idle_exit_locked0", 32'(locked), 32'(0));
        chk("idle_exit_qout", 32'(qout), 32'h71);
        cycle();

`ifdef FLOP_ARB_CNT_EN
        cnt_sel = 2'd2;
        @(negedge clk);
        chk("cnt2_one", 32'(cnt_out), 32'(1));
        wdata = {8'h00, 8'h00, 8'h81, 8'h00};
        for (int i = 0; i < 300; i++)
            push(4'b0010, 8'h81);
        req = 4'b0010;
        repeat (300) cycle();
        req     = '0;
        cnt_sel = 2'd1;
        @(negedge clk);
        chk("cnt1_sat", 32'(cnt_out), 32'(255));
        cycle();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt1_clr", 32'(cnt_out), 32'(0));
        cycle();
`endif

        repeat (2) cycle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flop_arbiter.md
FLOP_ARBITER -- requirements
Module: flop_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the register; range 2..8.
REQ-002 Parameter WIDTH, default 8: data width of the shared register.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 req  input  NREQ  per-requester write request; bit i belongs to requester i.
REQ-006 lock  input  NREQ  per-requester lock qualifier; meaningful only with req.
REQ-007 wdata  input  NREQ*WIDTH  write data; slice i is [i*WIDTH +: WIDTH].
REQ-008 gnt  output  NREQ  one-hot grant; at most one bit high in any cycle.
REQ-009 qout  output  WIDTH  contents of the shared register.
REQ-010 owner  output  $clog2(NREQ)  index of the last granted requester.
REQ-011 locked  output  1  high while the FSM is in LOCKED.

Function
REQ-012 gnt SHALL be combinational from req, state and the round-robin pointer, so it is valid in the same cycle that req is presented.
REQ-013 In IDLE, the grant SHALL go to the first requester with req high, searching upward from pointer ptr with wrap from NREQ-1 to 0.
REQ-014 On a granted cycle, the register SHALL load wdata slice of the grantee at that posedge, so qout shows the new value one cycle after gnt (latency 1).
REQ-015 After each grant in IDLE, ptr SHALL become (grantee+1) mod NREQ, and owner SHALL become the grantee.
REQ-016 With no req bit high, gnt SHALL be 0, and qout, ptr and owner SHALL hold.
REQ-017 Handshake: a requester SHALL hold req and wdata stable until it sees gnt. A req that stays high after its grant is treated as a new request.
REQ-018 FSM states are IDLE and LOCKED.
REQ-019 IDLE -> LOCKED when the grantee has lock high in its granted cycle.
REQ-020 In LOCKED, only requester owner is eligible. gnt[owner]=req[owner]. All other requests are ignored and are not dropped from their requesters.
REQ-021 LOCKED -> IDLE at the posedge where req[owner] is high and lock[owner] is low. That final write still occurs.
REQ-022 LOCKED -> IDLE also occurs at the posedge where req[owner] is low and lock[owner] is low; no write occurs in that cycle.
REQ-023 ptr SHALL stay frozen during LOCKED. On return to IDLE, ptr SHALL be (owner+1) mod NREQ.
REQ-024 locked SHALL be high in exactly the cycles where the state is LOCKED.

Reset
REQ-025 When reset=0 at a posedge, the block SHALL set: qout=0, ptr=0, owner=0, state=IDLE.
REQ-026 While reset=0 is present, gnt SHALL be forced to 0 combinationally.
REQ-027 Reset SHALL win over a simultaneous grant and load.
REQ-028 Reset asserted during LOCKED SHALL abandon the lock, with no final write.

Configuration
REQ-029 Macro FLOP_ARB_CNT_EN.
- Defined: the block adds inputs cnt_sel ($clog2(NREQ)) and cnt_clr (1), and output cnt_out (8).
- Defined: it keeps one 8-bit grant counter per requester, saturating at 255, incremented on each granted cycle of that requester.
- Defined: cnt_out = counter[cnt_sel], combinational. cnt_clr=1 zeroes all counters at the posedge, overriding any increment. Reset zeroes all counters.
- Not defined: these ports and the counters are absent, and all other behaviour is identical.

Structure
REQ-030 Package flop_arb_pkg SHALL hold:
- typedef enum logic {IDLE, LOCKED} arb_state_e;
- default constants NREQ_DEF=4, WIDTH_DEF=8, CNT_W=8.
REQ-031 The shared register SHALL be the sub-module flop_reg: WIDTH-bit, with ports clk, reset, load, d, q, synchronous active-low reset to 0. All arbitration and FSM logic stays in flop_arbiter.

Verification
REQ-032 Reset: hold reset=0 for 3 cycles with req=4'b1111 -> gnt=0 throughout; after release qout=8'h00, owner=0, locked=0.
REQ-033 Round-robin: req=4'b1111 held, wdata slices 8'h10/11/12/13 -> gnt sequence 0001,0010,0100,1000,0001; qout 8'h10,8'h11,8'h12,8'h13 one cycle after each grant.
REQ-034 Wrap and skip: ptr=3, req=4'b0101 -> gnt=0001, then ptr=1 and next gnt=0100.
REQ-035 Lock: requester 2 with req and lock, data 8'hA5 then 8'hA6, while req[0] is high throughout:
- gnt[0] stays 0 and locked=1 across both writes.
- Requester 2 then drops lock with req and data 8'hA7 -> write of 8'hA7, locked=0, next grant goes to requester 3 if requesting, else 0.
REQ-036 Reset in LOCKED: enter LOCKED, assert reset=0 with req[owner]=1 -> no write, state IDLE, qout=0.
REQ-037 With FLOP_ARB_CNT_EN defined:
- 300 grants to requester 1 -> cnt_out=255 with cnt_sel=1.
- cnt_clr pulse -> cnt_out=0 the following cycle.
